// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: data/address widths, PC step, FETCH/HOLD encodings.
// Optional misalignment detection is selected with the FETCH_ALIGN_CHECK_EN macro.
package instruction_fetch_pkg;

    localparam int PC_WIDTH = 32;
    localparam int DWIDTH   = 32;

    localparam logic [PC_WIDTH-1:0] PC_STEP       = 32'h0000_0004;
    localparam logic [PC_WIDTH-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Sequential word address; wraps modulo 2^PC_WIDTH by construction.
    function automatic logic [PC_WIDTH-1:0] pc_next(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC buffer used while decode is stalled.
// Clear wins over load, load wins over drain.
module fetch_hold_buf
    import instruction_fetch_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_drain,
    input  logic                i_clear,
    input  logic [DWIDTH-1:0]   i_instr,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_valid,
    output logic [DWIDTH-1:0]   o_instr,
    output logic [PC_WIDTH-1:0] o_pc
);

    logic                r_valid;
    logic [DWIDTH-1:0]   r_instr;
    logic [PC_WIDTH-1:0] r_pc;

    // Buffer storage and occupancy flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= {DWIDTH{1'b0}};
            r_pc    <= {PC_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_instr <= {DWIDTH{1'b0}};
            r_pc    <= {PC_WIDTH{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, req/ack instruction-memory port, stall hold buffer, branch redirect.
// Define FETCH_ALIGN_CHECK_EN to flag and park on misaligned redirect targets.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                fs_i_clk,
    input  logic                fs_i_rst,
    input  logic                fs_i_stall,
    input  logic                fs_i_change_pc,
    input  logic [PC_WIDTH-1:0] fs_i_alu_pc,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [DWIDTH-1:0]   fs_i_imem_data,
    output logic [DWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce,
    output logic                fs_o_misalign
);

    fetch_state_t        r_state, w_state_n;
    logic [PC_WIDTH-1:0] r_pc, w_pc_n;
    logic [PC_WIDTH-1:0] r_out_pc, w_out_pc_n;
    logic [DWIDTH-1:0]   r_out_instr, w_out_instr_n;
    logic                r_ce, w_ce_n;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_aligned;
    logic                w_req;
    logic                w_ack;
    logic                w_buf_load, w_buf_drain, w_buf_clear, w_buf_valid;
    logic [DWIDTH-1:0]   w_buf_instr;
    logic [PC_WIDTH-1:0] w_buf_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign, w_misalign_n;

    assign w_target      = fs_i_alu_pc;
    assign w_aligned     = (r_pc[1:0] == 2'b00);
    assign fs_o_misalign = r_misalign;

    // Misalign flag follows the alignment of the most recent redirect target.
    always_comb begin
        w_misalign_n = r_misalign;
        if (fs_i_change_pc) begin
            w_misalign_n = (fs_i_alu_pc[1:0] != 2'b00);
        end else begin
            w_misalign_n = r_misalign;
        end
    end

    // Misalign flag register.
    always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
        if (fs_i_rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_n;
        end
    end
`else
    assign w_target      = fs_i_alu_pc & PC_ALIGN_MASK;
    assign w_aligned     = 1'b1;
    assign fs_o_misalign = 1'b0;
`endif

    assign w_req          = (r_state == FETCH) && w_aligned && !fs_i_rst;
    assign w_ack          = fs_i_imem_ack && w_req;
    assign fs_o_imem_req  = w_req;
    assign fs_o_imem_addr = r_pc;

    fetch_hold_buf u_hold_buf (
        .i_clk   (fs_i_clk),
        .i_rst   (fs_i_rst),
        .i_load  (w_buf_load),
        .i_drain (w_buf_drain),
        .i_clear (w_buf_clear),
        .i_instr (fs_i_imem_data),
        .i_pc    (pc_next(r_pc)),
        .o_valid (w_buf_valid),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc)
    );

    // Next state, PC and decode outputs; a redirect overrides ack, stall and HOLD.
    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_out_instr_n = r_out_instr;
        w_out_pc_n    = r_out_pc;
        w_ce_n        = r_ce;
        w_buf_load    = 1'b0;
        w_buf_drain   = 1'b0;
        w_buf_clear   = 1'b0;
        if (fs_i_change_pc) begin
            w_pc_n      = w_target;
            w_buf_clear = 1'b1;
            w_ce_n      = 1'b0;
            w_state_n   = FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_ack) begin
                        w_pc_n = pc_next(r_pc);
                        if (fs_i_stall) begin
                            w_buf_load = 1'b1;
                            w_state_n  = HOLD;
                        end else begin
                            w_out_instr_n = fs_i_imem_data;
                            w_out_pc_n    = pc_next(r_pc);
                            w_ce_n        = 1'b1;
                        end
                    end else if (fs_i_stall) begin
                        w_ce_n = r_ce;
                    end else begin
                        w_ce_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (fs_i_stall) begin
                        w_state_n = HOLD;
                    end else begin
                        w_out_instr_n = w_buf_instr;
                        w_out_pc_n    = w_buf_pc;
                        w_ce_n        = w_buf_valid;
                        w_buf_drain   = 1'b1;
                        w_state_n     = FETCH;
                    end
                end
                default: begin
                    w_state_n = FETCH;
                end
            endcase
        end
    end

    // State, PC and registered decode-side outputs.
    always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
        if (fs_i_rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_out_instr <= {DWIDTH{1'b0}};
            r_out_pc    <= {PC_WIDTH{1'b0}};
            r_ce        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_out_instr <= w_out_instr_n;
            r_out_pc    <= w_out_pc_n;
            r_ce        <= w_ce_n;
        end
    end

    assign fs_o_instr = r_out_instr;
    assign fs_o_pc    = r_out_pc;
    assign fs_o_ce    = r_ce;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: reference model plus delivery scoreboard.
// Honours FETCH_ALIGN_CHECK_EN when the design is built with it.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        change_pc;
    logic [31:0] alu_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        o_misalign;

    int n_cmp;
    int n_err;

    // Reference model of the fetch stage
    logic [31:0] m_pc;
    logic        m_hold;
    logic        m_mis;
    logic        m_ce;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic [63:0] exp_q[$];

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .fs_i_clk       (clk),
        .fs_i_rst       (rst),
        .fs_i_stall     (stall),
        .fs_i_change_pc (change_pc),
        .fs_i_alu_pc    (alu_pc),
        .fs_o_imem_req  (imem_req),
        .fs_o_imem_addr (imem_addr),
        .fs_i_imem_ack  (imem_ack),
        .fs_i_imem_data (imem_data),
        .fs_o_instr     (o_instr),
        .fs_o_pc        (o_pc),
        .fs_o_ce        (o_ce),
        .fs_o_misalign  (o_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock cycle: drive inputs, check the request side, advance model, check outputs.
    task automatic step(input logic ack, input logic stl, input logic chg, input logic [31:0] alu);
        logic        req_exp;
        logic        acked;
        logic        deliver;
        logic [63:0] e;
        stall     = stl;
        change_pc = chg;
        alu_pc    = alu;
        imem_ack  = ack;
        imem_data = mem_word(m_pc);
        req_exp   = !m_hold && !m_mis;
        #2;
        n_cmp++;
        if (imem_req !== req_exp) begin
            n_err++;
            $display("FAIL req: got %b expected %b (model pc %h)", imem_req, req_exp, m_pc);
        end
        if (req_exp) begin
            n_cmp++;
            if (imem_addr !== m_pc) begin
                n_err++;
                $display("FAIL addr: got %h expected %h", imem_addr, m_pc);
            end
        end
        acked   = ack && req_exp;
        deliver = 1'b0;
        if (chg) begin
            if (m_hold) begin
                m_hold = 1'b0;
                void'(exp_q.pop_back());
            end
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc  = alu;
            m_mis = (alu[1:0] != 2'b00);
`else
            m_pc  = alu & 32'hFFFF_FFFC;
`endif
            m_ce  = 1'b0;
        end else if (m_hold) begin
            if (!stl) begin
                m_hold  = 1'b0;
                deliver = 1'b1;
                m_ce    = 1'b1;
            end
        end else if (acked) begin
            exp_q.push_back({m_pc + 32'd4, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
            if (stl) begin
                m_hold = 1'b1;
            end else begin
                deliver = 1'b1;
                m_ce    = 1'b1;
            end
        end else if (!stl) begin
            m_ce = 1'b0;
        end
        @(posedge clk);
        #1;
        if (deliver) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: delivery with empty queue");
            end else begin
                e          = exp_q.pop_front();
                last_pc    = e[63:32];
                last_instr = e[31:0];
            end
        end
        n_cmp++;
        if (o_ce !== m_ce) begin
            n_err++;
            $display("FAIL ce: got %b expected %b", o_ce, m_ce);
        end
        n_cmp++;
        if (o_pc !== last_pc || o_instr !== last_instr) begin
            n_err++;
            $display("FAIL out: got pc %h instr %h expected pc %h instr %h", o_pc, o_instr, last_pc, last_instr);
        end
        n_cmp++;
        if (o_misalign !== m_mis) begin
            n_err++;
            $display("FAIL misalign: got %b expected %b", o_misalign, m_mis);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_hold     = 1'b0;
        m_mis      = 1'b0;
        m_ce       = 1'b0;
        last_pc    = 32'h0000_0000;
        last_instr = 32'h0000_0000;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        stall     = 1'b0;
        change_pc = 1'b0;
        alu_pc    = 32'h0000_0000;
        imem_ack  = 1'b1;
        imem_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (o_ce !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_misalign !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: ce %b pc %h instr %h mis %b expected all zero", o_ce, o_pc, o_instr, o_misalign);
        end
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 9; i++) step((i % 3) == 2, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_stall_on_ack();
        test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0BAD);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        step(1'b1, 1'b0, 1'b1, 32'h0000_0202);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_ce !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0 || imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL async_reset: ce %b pc %h instr %h addr %h", o_ce, o_pc, o_instr, imem_addr);
        end
        test_reset();
        test_back_to_back();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_stall_on_ack();
        test_redirect();
        test_wrap();
        test_misalign();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, issues word requests to instruction memory through a req/ack handshake and presents fetched instructions with their PC+4 to the decode stage. It is the consumer of the execute stage's branch-redirect pair (change-PC strobe plus target PC). It honours hazard-unit stalls through a one-entry hold buffer, so no fetched word is lost or duplicated.

## Interface
- RESET_PC, 0, PC loaded on reset; width `PC_WIDTH`, must be word-aligned
- fs_i_clk  in  1  clock, rising edge
- fs_i_rst  in  1  asynchronous, active-high reset
- fs_i_stall  in  1  hazard unit: decode cannot accept; hold outputs
- fs_i_change_pc  in  1  execute-stage branch taken (redirect strobe)
- fs_i_alu_pc  in  `PC_WIDTH`  redirect target; valid only with fs_i_change_pc
- fs_o_imem_req  out  1  instruction-memory request
- fs_o_imem_addr  out  `PC_WIDTH`  byte address of requested word
- fs_i_imem_ack  in  1  memory returns data for current fs_o_imem_addr this cycle
- fs_i_imem_data  in  `DWIDTH`  instruction word, valid with ack
- fs_o_instr  out  `DWIDTH`  instruction to decode
- fs_o_pc  out  `PC_WIDTH`  address of fs_o_instr plus 4
- fs_o_ce  out  1  fs_o_instr/fs_o_pc valid (feeds the pipeline ce chain)
- fs_o_misalign  out  1  only with FETCH_ALIGN_CHECK_EN; see Configuration

## Operation
- State machine, 2 states: FETCH (req asserted), HOLD (word buffered while stalled, req low).
- Reset: pc = RESET_PC, state = FETCH, hold buffer empty, fs_o_instr = 0, fs_o_pc = 0, fs_o_ce = 0, fs_o_misalign = 0.
- fs_o_imem_req = (state == FETCH) && !fs_i_rst. fs_o_imem_addr = pc, combinational from the register.
- Handshake rules:
  - An ack counts only while req is high.
  - The memory does not commit to a request before acking, so addr may change between cycles without an abort.
  - An ack that arrives while req is low is ignored.
- FETCH with ack, no stall, no redirect: fs_o_instr <= data, fs_o_pc <= pc+4, fs_o_ce <= 1, pc <= pc+4.
- FETCH, no ack, no stall: fs_o_ce <= 0 (bubble); pc unchanged.
- FETCH with ack and stall: capture data and pc+4 into the hold buffer; pc <= pc+4; go to HOLD. Outputs keep their values.
- HOLD with stall: everything unchanged.
- HOLD without stall: move the buffer to the outputs with fs_o_ce <= 1; go to FETCH.
- Stall with no ack (either state): outputs and pc hold.
- Redirect (fs_i_change_pc = 1) has top priority over stall, ack and HOLD:
  - pc <= fs_i_alu_pc.
  - A same-cycle ack is discarded, and the hold buffer is emptied.
  - fs_o_ce <= 0; state <= FETCH.
  - The request for the target issues the next cycle.
- PC arithmetic is modulo 2^`PC_WIDTH`: 0xFFFFFFFC+4 wraps to 0 with no flag.
- fs_i_alu_pc is ignored when fs_i_change_pc = 0.

## Timing
- Zero-wait memory (ack in the request cycle) gives 1 instruction per cycle. fs_o_ce rises on the edge that ends the ack cycle.
- Redirect-to-request latency: 1 cycle. Redirect-to-fs_o_ce latency: 2 cycles minimum. fs_o_ce is low on the edge after the redirect.
- Stall release from HOLD delivers on the next edge. The new request issues in the cycle after that.
- Reset assertion mid-operation clears all state asynchronously, with no memory handshake cleanup. The first request goes out in the first cycle with reset low.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect target with fs_i_alu_pc[1:0] != 0 is still loaded into pc, but no request is issued while pc is misaligned.
  - fs_o_misalign is set and held until reset or until an aligned redirect.
  - fs_o_ce stays 0 throughout.
- Macro undefined:
  - fs_o_misalign is tied to 0.
  - Bits [1:0] of the redirect target are forced to 0 before loading pc.

## Structure
- Use `PC_WIDTH` and `DWIDTH` from the shared header.
- Add the FETCH/HOLD state encodings and the constant instruction-word step 4 (`PC_STEP`) to the shared header.
- One natural sub-module: fetch_hold_buf, the one-entry instruction/PC buffer with load, drain and clear.

## Test plan
- Reset: RESET_PC=0x100, release reset, ack every cycle with data=addr -> addr sequence 0x100, 0x104, 0x108. fs_o_pc 0x104, 0x108, … one cycle later. fs_o_ce stays 1.
- Wait states: ack every third cycle -> fs_o_ce pulses once per 3 cycles. pc advances only on ack. No duplicated fs_o_pc value.
- Stall on ack: stall=1 in the ack cycle for addr 0x108, hold 3 cycles -> outputs stay at 0x108's predecessor, req low. On release, fs_o_pc=0x10C with ce=1, then a request for 0x10C.
- Redirect: change_pc=1, alu_pc=0x200, concurrent ack and stall -> next addr 0x200, fs_o_ce=0 for one cycle, then fs_o_pc=0x204.
- Wrap-around: redirect to 0xFFFFFFFC with ack -> next addr 0x00000000, fs_o_pc=0x00000000.
- FETCH_ALIGN_CHECK_EN defined: redirect to 0x202 -> fs_o_misalign=1, req=0, ce=0. A following redirect to 0x300 clears it and fetches 0x300.
